ysyx_22041752_commit_queue: RTL and testbench

Commit-side producer for the simulation trace path. Accepts one retired-instruction record per cycle from the writeback stage with a valid/ready handshake, buffers records in a small FIFO, and presents them in order to the DPI trace consumer on a second valid/ready port. It also maintains cycle, instret and cache-miss event counters, and a sticky halt flag. This decouples writeback from the simulator's sampling point, so no record is lost or duplicated when the consumer stalls.

---
 rtl/ysyx_22041752_pkg.sv | 20 ++
 rtl/ysyx_22041752_sync_fifo.sv | 48 ++++
 rtl/ysyx_22041752_commit_queue.sv | 113 +++++++++++
 tb/tb_ysyx_22041752_commit_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041752_pkg.sv
// Shared widths, commit-record layout and flag bit positions for the
// ysyx_22041752 trace path.
package ysyx_22041752_pkg;

  localparam int RF_WD   = 64;
  localparam int INST_WD = 32;

  localparam int FLAG_EXP  = 0;
  localparam int FLAG_MRET = 1;
  localparam int FLAG_OOM  = 2;
  localparam int FLAG_HALT = 3;

  typedef struct packed {
    logic [RF_WD-1:0]   pc;
    logic [RF_WD-1:0]   dnpc;
    logic [INST_WD-1:0] inst;
    logic [3:0]         flags;
  } commit_rec_t;

endpackage

// File: rtl/ysyx_22041752_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the read port shows the entry at
// the read pointer directly, so a push becomes visible one edge later.
module ysyx_22041752_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage is cleared on reset so the read port never presents X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/ysyx_22041752_commit_queue.sv
// Commit-record queue between writeback and the trace consumer, plus cycle,
// instret, cache-miss counters and the sticky halt flag.
module ysyx_22041752_commit_queue
  import ysyx_22041752_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_WD   = 64,
  parameter int INST_WD = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ws_valid,
  output logic               ws_ready,
  input  logic [PC_WD-1:0]   ws_pc,
  input  logic [PC_WD-1:0]   ws_dnpc,
  input  logic [INST_WD-1:0] ws_inst,
  input  logic [3:0]         ws_flags,
  output logic               tr_valid,
  input  logic               tr_ready,
  output logic [PC_WD-1:0]   tr_pc,
  output logic [PC_WD-1:0]   tr_dnpc,
  output logic [INST_WD-1:0] tr_inst,
  output logic [3:0]         tr_flags,
  input  logic               icache_miss,
  input  logic               dcache_miss,
  output logic [63:0]        cycle_cnt,
  output logic [63:0]        instret_cnt,
  output logic [31:0]        imiss_cnt,
  output logic [31:0]        dmiss_cnt,
  output logic               halted
);

  localparam int REC_W = 2 * PC_WD + INST_WD + 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [REC_W-1:0] w_wdata;
  logic [REC_W-1:0] w_rdata;

  logic        r_halted;
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;
  logic [31:0] r_imiss_cnt;
  logic [31:0] r_dmiss_cnt;
  logic        r_imiss_s, r_imiss_d;
  logic        r_dmiss_s, r_dmiss_d;

  assign ws_ready = !w_full && !r_halted;
  assign tr_valid = !w_empty;
  assign w_push   = ws_valid && ws_ready;
  assign w_pop    = tr_valid && tr_ready;
  assign w_wdata  = {ws_pc, ws_dnpc, ws_inst, ws_flags};

  assign tr_flags = w_rdata[3:0];
  assign tr_inst  = w_rdata[INST_WD+3:4];
  assign tr_dnpc  = w_rdata[PC_WD+INST_WD+3:INST_WD+4];
  assign tr_pc    = w_rdata[REC_W-1:PC_WD+INST_WD+4];

  ysyx_22041752_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Miss inputs are first sampled, then compared with a delayed copy, so a
  // rise is counted one edge after it is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted      <= 1'b0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
      r_imiss_cnt   <= '0;
      r_dmiss_cnt   <= '0;
      r_imiss_s     <= 1'b0;
      r_imiss_d     <= 1'b0;
      r_dmiss_s     <= 1'b0;
      r_dmiss_d     <= 1'b0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      r_imiss_s   <= icache_miss;
      r_imiss_d   <= r_imiss_s;
      r_dmiss_s   <= dcache_miss;
      r_dmiss_d   <= r_dmiss_s;
      if (r_imiss_s && !r_imiss_d) r_imiss_cnt <= sat_inc(r_imiss_cnt);
      if (r_dmiss_s && !r_dmiss_d) r_dmiss_cnt <= sat_inc(r_dmiss_cnt);
      if (w_pop) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
        if (tr_flags[FLAG_HALT]) r_halted <= 1'b1;
      end
    end
  end

  assign halted      = r_halted;
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
  assign imiss_cnt   = r_imiss_cnt;
  assign dmiss_cnt   = r_dmiss_cnt;

endmodule

// File: tb/tb_ysyx_22041752_commit_queue.sv
// Directed bench for the commit queue: ordering, full/back-pressure, wrap,
// halt behaviour, miss counters and mid-stream reset.
module tb_ysyx_22041752_commit_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid;
  logic        ws_ready;
  logic [63:0] ws_pc, ws_dnpc;
  logic [31:0] ws_inst;
  logic [3:0]  ws_flags;
  logic        tr_valid;
  logic        tr_ready;
  logic [63:0] tr_pc, tr_dnpc;
  logic [31:0] tr_inst;
  logic [3:0]  tr_flags;
  logic        icache_miss, dcache_miss;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [31:0] imiss_cnt, dmiss_cnt;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22041752_commit_queue #(.DEPTH(4), .PC_WD(64), .INST_WD(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .ws_valid    (ws_valid),
    .ws_ready    (ws_ready),
    .ws_pc       (ws_pc),
    .ws_dnpc     (ws_dnpc),
    .ws_inst     (ws_inst),
    .ws_flags    (ws_flags),
    .tr_valid    (tr_valid),
    .tr_ready    (tr_ready),
    .tr_pc       (tr_pc),
    .tr_dnpc     (tr_dnpc),
    .tr_inst     (tr_inst),
    .tr_flags    (tr_flags),
    .icache_miss (icache_miss),
    .dcache_miss (dcache_miss),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt),
    .imiss_cnt   (imiss_cnt),
    .dmiss_cnt   (dmiss_cnt),
    .halted      (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [63:0] pc, input logic [3:0] fl);
    ws_pc    = pc;
    ws_dnpc  = pc + 64'd4;
    ws_inst  = pc[31:0] ^ 32'h0000_0013;
    ws_flags = fl;
  endtask

  task automatic do_reset();
    reset = 1'b1; ws_valid = 1'b0; tr_ready = 1'b0;
    icache_miss = 1'b0; dcache_miss = 1'b0;
    set_rec(64'h0, 4'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL reset_tr_valid: got %b want 0", tr_valid); end
    checks++; if (ws_ready !== 1'b1) begin errors++; $display("FAIL reset_ws_ready: got %b want 1", ws_ready); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (tr_pc !== 64'h0) begin errors++; $display("FAIL reset_tr_pc: got %h want 0", tr_pc); end
    checks++; if ({cycle_cnt, instret_cnt, imiss_cnt, dmiss_cnt} !== '0) begin
      errors++; $display("FAIL reset_counters: cyc %0d ins %0d im %0d dm %0d want all 0",
                         cycle_cnt, instret_cnt, imiss_cnt, dmiss_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (cycle_cnt !== 64'd5) begin errors++; $display("FAIL cycle_cnt: got %0d want 5", cycle_cnt); end
  endtask

  task automatic test_in_order();
    logic [63:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ws_valid = 1'b1;
      set_rec(64'h8000_0000 + 64'(4 * i), 4'h0);
      tick();
      if (i == 0) begin
        checks++; if (tr_valid !== 1'b1) begin errors++; $display("FAIL first_visible: got %b want 1", tr_valid); end
      end
    end
    ws_valid = 1'b0;
    tr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 64'h8000_0000 + 64'(4 * i);
      checks++; if (tr_valid !== 1'b1 || tr_pc !== exp_pc || tr_dnpc !== exp_pc + 64'd4 ||
                    tr_inst !== (exp_pc[31:0] ^ 32'h13)) begin
        errors++; $display("FAIL order_pop%0d: got v=%b pc=%h dnpc=%h inst=%h want pc=%h", i,
                           tr_valid, tr_pc, tr_dnpc, tr_inst, exp_pc); end
      tick();
    end
    tr_ready = 1'b0;
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL order_empty: got %b want 0", tr_valid); end
    checks++; if (instret_cnt !== 64'd3) begin errors++; $display("FAIL order_instret: got %0d want 3", instret_cnt); end
  endtask

  task automatic test_full();
    logic [63:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ws_valid = 1'b1;
      set_rec(64'h1000 + 64'(4 * i), 4'h0);
      tick();
    end
    checks++; if (ws_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", ws_ready); end
    set_rec(64'h2000, 4'h0);
    tick();
    checks++; if (ws_ready !== 1'b0 || tr_pc !== 64'h1000) begin
      errors++; $display("FAIL full_reject: ready=%b pc=%h want 0/1000", ws_ready, tr_pc); end
    tr_ready = 1'b1;
    tick();
    ws_valid = 1'b0;
    checks++; if (ws_ready !== 1'b1 || tr_pc !== 64'h1004) begin
      errors++; $display("FAIL full_pop_only: ready=%b pc=%h want 1/1004", ws_ready, tr_pc); end
    for (int i = 1; i < 4; i++) begin
      exp_pc = 64'h1000 + 64'(4 * i);
      checks++; if (tr_valid !== 1'b1 || tr_pc !== exp_pc) begin
        errors++; $display("FAIL full_drain%0d: v=%b pc=%h want 1/%h", i, tr_valid, tr_pc, exp_pc); end
      tick();
    end
    tr_ready = 1'b0;
    checks++; if (tr_valid !== 1'b0 || instret_cnt !== 64'd4) begin
      errors++; $display("FAIL full_end: v=%b instret=%0d want 0/4", tr_valid, instret_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_pc;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ws_valid = 1'b1;
      set_rec(64'h3000 + 64'(4 * i), 4'h0);
      tick();
    end
    tr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_rec(64'h3008 + 64'(4 * k), 4'h0);
      exp_pc = 64'h3000 + 64'(4 * k);
      checks++; if (tr_pc !== exp_pc || ws_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d: pc=%h ready=%b want %h/1", k, tr_pc, ws_ready, exp_pc); end
      tick();
    end
    ws_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      exp_pc = 64'h3000 + 64'(4 * k);
      checks++; if (tr_valid !== 1'b1 || tr_pc !== exp_pc) begin
        errors++; $display("FAIL b2b_tail%0d: v=%b pc=%h want 1/%h", k, tr_valid, tr_pc, exp_pc); end
      tick();
    end
    tr_ready = 1'b0;
    checks++; if (tr_valid !== 1'b0 || instret_cnt !== 64'd12) begin
      errors++; $display("FAIL b2b_end: v=%b instret=%0d want 0/12", tr_valid, instret_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    ws_valid = 1'b1;
    set_rec(64'h4000, 4'b1000);
    tick();
    set_rec(64'h4004, 4'b0000);
    tick();
    ws_valid = 1'b0;
    checks++; if (tr_flags !== 4'b1000 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_head: flags=%b halted=%b want 1000/0", tr_flags, halted); end
    tr_ready = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || ws_ready !== 1'b0) begin
      errors++; $display("FAIL halt_set: halted=%b ready=%b want 1/0", halted, ws_ready); end
    checks++; if (tr_valid !== 1'b1 || tr_pc !== 64'h4004) begin
      errors++; $display("FAIL halt_next: v=%b pc=%h want 1/4004", tr_valid, tr_pc); end
    tick();
    tr_ready = 1'b0;
    checks++; if (tr_valid !== 1'b0 || halted !== 1'b1 || instret_cnt !== 64'd2) begin
      errors++; $display("FAIL halt_drain: v=%b halted=%b instret=%0d want 0/1/2", tr_valid, halted, instret_cnt); end
    do_reset();
    checks++; if (halted !== 1'b0 || ws_ready !== 1'b1) begin
      errors++; $display("FAIL halt_clear: halted=%b ready=%b want 0/1", halted, ws_ready); end
  endtask

  task automatic test_miss();
    do_reset();
    icache_miss = 1'b1;
    tick();
    checks++; if (imiss_cnt !== 32'd0) begin errors++; $display("FAIL imiss_latency: got %0d want 0", imiss_cnt); end
    tick();
    checks++; if (imiss_cnt !== 32'd1) begin errors++; $display("FAIL imiss_first: got %0d want 1", imiss_cnt); end
    for (int i = 0; i < 3; i++) tick();
    icache_miss = 1'b0;
    tick(); tick();
    checks++; if (imiss_cnt !== 32'd1) begin errors++; $display("FAIL imiss_level: got %0d want 1", imiss_cnt); end
    icache_miss = 1'b1;
    tick(); tick();
    icache_miss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dcache_miss = 1'b1; tick();
      dcache_miss = 1'b0; tick();
    end
    tick(); tick();
    checks++; if (imiss_cnt !== 32'd2) begin errors++; $display("FAIL imiss_total: got %0d want 2", imiss_cnt); end
    checks++; if (dmiss_cnt !== 32'd3) begin errors++; $display("FAIL dmiss_total: got %0d want 3", dmiss_cnt); end
    ws_valid = 1'b1;
    set_rec(64'h5000, 4'h0);
    tick();
    icache_miss = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; ws_valid = 1'b0; icache_miss = 1'b0;
    checks++; if (tr_valid !== 1'b0 || ws_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_queue: v=%b ready=%b want 0/1", tr_valid, ws_ready); end
    checks++; if ({cycle_cnt, instret_cnt, imiss_cnt, dmiss_cnt} !== '0) begin
      errors++; $display("FAIL midreset_counters: cyc %0d ins %0d im %0d dm %0d want all 0",
                         cycle_cnt, instret_cnt, imiss_cnt, dmiss_cnt); end
    tick(); tick();
    checks++; if (imiss_cnt !== 32'd0 || tr_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_after: im=%0d v=%b want 0/0", imiss_cnt, tr_valid); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_back_to_back();
    test_halt();
    test_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
